// File: rtl/msg_pkg.sv
// Shared types and defaults for the outgoing-message queue.
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/msg_queue_mem.sv
// Message storage: register array with synchronous write and asynchronous read, no reset.
module msg_queue_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/msg_queue.sv
// Outgoing-message queue: captures a message on each ready rising edge and paces
// them out to the UART transmitter with an enforced inter-byte gap.
module msg_queue
    import msg_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter bit          OVERWRITE  = 1'b0
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       clear,
    input  logic                       ready,
    input  logic [DATA_W-1:0]          data,
    input  logic                       transmit_ready,
    output logic                       blue,
    output logic                       tx_ctrl,
    output logic [DATA_W-1:0]          tx_byte,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    tx_state_t         r_state, w_state_nxt;
    logic [GW-1:0]     r_gap, w_gap_nxt;
    logic [AW-1:0]     r_wr, r_rd, w_wr_nxt, w_rd_nxt;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic              r_overflow, w_overflow_nxt;
    logic              r_ready_q, r_blue, r_full, r_tx_ctrl;
    logic [DATA_W-1:0] r_tx_byte, w_rdata;
    logic              w_push, w_pop, w_is_full, w_accept, w_we, w_load;

    assign w_push    = ready & ~r_ready_q;
    assign w_pop     = (r_state == SEND) && (r_count != '0);
    assign w_is_full = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a push on a full queue is still accepted
    assign w_accept  = w_push && (!w_is_full || w_pop);
    assign w_load    = (r_state == IDLE) && (w_state_nxt == SEND);

    msg_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr),
        .i_wdata (data),
        .i_raddr (r_rd),
        .o_rdata (w_rdata)
    );

    // Transmit pacing FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        case (r_state)
            IDLE: if ((r_count != '0) && transmit_ready) w_state_nxt = SEND;
            SEND: begin
                w_state_nxt = GAP;
                w_gap_nxt   = GW'(GAP_CYCLES - 1);
            end
            GAP: begin
                if (r_gap == '0) w_state_nxt = IDLE;
                else             w_gap_nxt   = r_gap - GW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
        end
    end

    // Pointer, occupancy and overflow next state
    always_comb begin
        w_wr_nxt       = r_wr;
        w_rd_nxt       = r_rd;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_we           = 1'b0;
        if (clear) begin
            w_wr_nxt       = '0;
            w_rd_nxt       = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_accept) begin
                w_we     = 1'b1;
                w_wr_nxt = r_wr + AW'(1);
            end else if (w_push) begin
                w_overflow_nxt = 1'b1;
                if (OVERWRITE) begin
                    w_we     = 1'b1;
                    w_wr_nxt = r_wr + AW'(1);
                    w_rd_nxt = r_rd + AW'(1);
                end
            end
            if (w_pop) w_rd_nxt = r_rd + AW'(1);
            if (w_accept && !w_pop)      w_count_nxt = r_count + CW'(1);
            else if (!w_accept && w_pop) w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_gap      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ready_q  <= 1'b0;
            r_blue     <= 1'b0;
            r_full     <= 1'b0;
            r_tx_ctrl  <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap      <= w_gap_nxt;
            r_wr       <= w_wr_nxt;
            r_rd       <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_ready_q  <= ready;
            r_blue     <= (w_count_nxt != '0);
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_tx_ctrl  <= (w_state_nxt == SEND);
            if (w_load) r_tx_byte <= w_rdata;
        end
    end

    assign blue     = r_blue;
    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_ctrl  = r_tx_ctrl;
    assign tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_msg_queue.sv
// Directed bench for msg_queue: instance a drops on full, instance b overwrites oldest.
module tb_msg_queue;

    logic       clk = 1'b0;
    logic       nRst, clear, ready, transmit_ready;
    logic [7:0] data;
    logic       blue_a, tx_ctrl_a, full_a, overflow_a;
    logic       blue_b, tx_ctrl_b, full_b, overflow_b;
    logic [7:0] tx_byte_a, tx_byte_b;
    logic [2:0] count_a, count_b;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ca[$];

    always #5 clk = ~clk;

    msg_queue #(.DATA_W(8), .DEPTH(4), .GAP_CYCLES(2), .OVERWRITE(1'b0)) u_dut_a (
        .clk(clk), .nRst(nRst), .clear(clear), .ready(ready), .data(data),
        .transmit_ready(transmit_ready), .blue(blue_a), .tx_ctrl(tx_ctrl_a),
        .tx_byte(tx_byte_a), .full(full_a), .count(count_a), .overflow(overflow_a)
    );

    msg_queue #(.DATA_W(8), .DEPTH(4), .GAP_CYCLES(2), .OVERWRITE(1'b1)) u_dut_b (
        .clk(clk), .nRst(nRst), .clear(clear), .ready(ready), .data(data),
        .transmit_ready(transmit_ready), .blue(blue_b), .tx_ctrl(tx_ctrl_b),
        .tx_byte(tx_byte_b), .full(full_b), .count(count_b), .overflow(overflow_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; samples 1 ns after the edge and logs any transmit pulse
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_ctrl_a) begin
            qa.push_back(tx_byte_a);
            ca.push_back(cyc);
        end
        if (tx_ctrl_b) qb.push_back(tx_byte_b);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] b);
        data  = b;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
    endtask

    task automatic flush_logs();
        qa.delete();
        qb.delete();
        ca.delete();
    endtask

    // Expect the logged bytes of one instance to be base, base+1, ... (n entries)
    task automatic chk_seq(input string tag, input int sel, input int base, input int n);
        int sz;
        sz = (sel == 0) ? qa.size() : qb.size();
        chk($sformatf("%s_n", tag), 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < sz)
                chk($sformatf("%s_%0d", tag, i), 32'((sel == 0) ? qa[i] : qb[i]), 32'(base + i));
        end
    endtask

    initial begin
        nRst = 1'b0; clear = 1'b0; ready = 1'b0; transmit_ready = 1'b0; data = 8'h00;
        run(2);
        chk("rst_txc", 32'(tx_ctrl_a), 0);
        chk("rst_blue", 32'(blue_a), 0);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_cnt", 32'(count_a), 0);
        chk("rst_ovf", 32'(overflow_a), 0);
        chk("rst_byte", 32'(tx_byte_a), 0);
        nRst = 1'b1;
        run(2);

        // Held ready pushes once; first pulse two cycles after ready rises
        flush_logs();
        data = 8'd5; transmit_ready = 1'b1; ready = 1'b1;
        tick();
        chk("t2_c1_txc", 32'(tx_ctrl_a), 0);
        chk("t2_c1_blue", 32'(blue_a), 1);
        chk("t2_c1_cnt", 32'(count_a), 1);
        tick();
        chk("t2_c2_txc", 32'(tx_ctrl_a), 1);
        chk("t2_c2_byte", 32'(tx_byte_a), 5);
        tick();
        chk("t2_c3_txc", 32'(tx_ctrl_a), 0);
        chk("t2_c3_blue", 32'(blue_a), 0);
        run(2);
        ready = 1'b0;
        run(8);
        chk_seq("t2_seq", 0, 5, 1);

        // Buffer three while blocked, then drain in order with 4-cycle spacing
        flush_logs();
        transmit_ready = 1'b0;
        push(8'h41); push(8'h42); push(8'h43);
        chk("t3_cnt", 32'(count_a), 3);
        chk("t3_blue", 32'(blue_a), 1);
        chk("t3_nopulse", 32'(qa.size()), 0);
        transmit_ready = 1'b1;
        run(20);
        chk_seq("t3_seq", 0, 8'h41, 3);
        if (ca.size() == 3) begin
            chk("t3_gap01", 32'(ca[1] - ca[0]), 4);
            chk("t3_gap12", 32'(ca[2] - ca[1]), 4);
        end
        chk("t3_end_cnt", 32'(count_a), 0);

        // Overfill: drop newest (a) vs overwrite oldest (b)
        flush_logs();
        transmit_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        chk("t4a_full", 32'(full_a), 1);
        chk("t4a_ovf", 32'(overflow_a), 1);
        chk("t4a_cnt", 32'(count_a), 4);
        chk("t4b_full", 32'(full_b), 1);
        chk("t4b_ovf", 32'(overflow_b), 1);
        chk("t4b_cnt", 32'(count_b), 4);
        transmit_ready = 1'b1;
        run(25);
        chk_seq("t4a_seq", 0, 8'h10, 4);
        chk_seq("t4b_seq", 1, 8'h11, 4);
        chk("t4a_sticky", 32'(overflow_a), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4a_clr_ovf", 32'(overflow_a), 0);
        chk("t4b_clr_ovf", 32'(overflow_b), 0);
        run(4);

        // Push on a full queue in the same cycle as a pop
        flush_logs();
        transmit_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
        chk("t5_full", 32'(full_a), 1);
        data = 8'h24;
        transmit_ready = 1'b1;
        tick();
        chk("t5_send", 32'(tx_ctrl_a), 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t5a_cnt", 32'(count_a), 4);
        chk("t5a_ovf", 32'(overflow_a), 0);
        chk("t5b_ovf", 32'(overflow_b), 0);
        run(25);
        chk_seq("t5a_seq", 0, 8'h20, 5);
        chk_seq("t5b_seq", 1, 8'h20, 5);

        // Clear wins over a coincident push
        flush_logs();
        transmit_ready = 1'b0;
        push(8'h30); push(8'h31); push(8'h32);
        chk("t6_cnt3", 32'(count_a), 3);
        clear = 1'b1; ready = 1'b1; data = 8'h33;
        tick();
        clear = 1'b0; ready = 1'b0;
        chk("t6_cnt", 32'(count_a), 0);
        chk("t6_blue", 32'(blue_a), 0);
        chk("t6_ovf", 32'(overflow_a), 0);
        transmit_ready = 1'b1;
        run(10);
        chk("t6_nopulse", 32'(qa.size()), 0);

        // Asynchronous reset while in GAP with two entries left
        flush_logs();
        transmit_ready = 1'b0;
        push(8'h50); push(8'h51); push(8'h52);
        transmit_ready = 1'b1;
        tick();
        chk("t1_send", 32'(tx_ctrl_a), 1);
        tick();
        chk("t1_cnt2", 32'(count_a), 2);
        #2 nRst = 1'b0;
        #1;
        chk("t1_cnt", 32'(count_a), 0);
        chk("t1_blue", 32'(blue_a), 0);
        chk("t1_byte", 32'(tx_byte_a), 0);
        chk("t1_txc", 32'(tx_ctrl_a), 0);
        chk("t1_full", 32'(full_a), 0);
        run(2);
        nRst = 1'b1;
        flush_logs();
        run(10);
        chk("t1_nopulse", 32'(qa.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
